ser_tx: RTL

Serial frame transmitter that drives the single-wire link consumed by the serial receiver (`ser_comm`). Accepts a parallel payload word over a valid/ready handshake, then serializes a fixed 6-bit header (0-1-1-0-1-0) followed by the payload, MSB first, one bit per clock. The line idles high between frames. Sits at the sending end of the link, fed by any producer with a payload-wide word.

---
 rtl/ser_tx.sv | 111 +++++++++++
 1 files changed

// File: rtl/ser_tx.sv
// Serial frame transmitter: accepts a payload word over valid/ready, then drives a fixed
// header followed by the payload (MSB first) on a registered, idle-high serial line.
module ser_tx #(
   parameter int unsigned PAYLOAD_W  = 32,
   parameter logic [5:0]  HEADER     = 6'b011010,
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [PAYLOAD_W-1:0] data_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   output logic                 serdata_o,
   output logic                 busy_o,
   output logic                 done_o
);

   localparam int CNT_W = (PAYLOAD_W > 1) ? $clog2(PAYLOAD_W) : 1;
   // Header bits 4..0 ride ahead of the payload; header bit 5 goes straight to the line.
   localparam int SH_W  = PAYLOAD_W + 5;

   localparam logic [CNT_W-1:0] HDR_TC = CNT_W'(5);
   localparam logic [CNT_W-1:0] PAY_TC = CNT_W'(PAYLOAD_W - 1);
   localparam logic [CNT_W-1:0] GAP_TC = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HEADER,
      S_PAYLOAD,
      S_GAP
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SH_W-1:0]   sh_q, sh_d;
   logic              ser_q, ser_d;
   logic              accept;

   assign ready_o   = (state_q == S_IDLE);
   assign accept    = valid_i && ready_o;
   assign busy_o    = (state_q != S_IDLE);
   assign done_o    = (state_q == S_PAYLOAD) && (cnt_q == PAY_TC);
   assign serdata_o = ser_q;

   // NOTE: the shift register is reset too, so an abandoned frame leaves no stale payload.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         ser_q   <= 1'b1;
      end else begin
         // NOTE: non-blocking here so every register samples the pre-edge values together.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         ser_q   <= ser_d;
      end
   end

   // ser_d is the bit the line will carry next cycle, keeping serdata_o a plain flop output.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      sh_d    = sh_q;
      ser_d   = ser_q;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            ser_d = 1'b1;
            if (accept) begin
               state_d = S_HEADER;
               ser_d   = HEADER[5];
               sh_d    = {HEADER[4:0], data_i};
            end
         end
         S_HEADER: begin
            ser_d = sh_q[SH_W-1];
            sh_d  = {sh_q[SH_W-2:0], 1'b0};
            if (cnt_q == HDR_TC) begin
               state_d = S_PAYLOAD;
               cnt_d   = '0;
            end
         end
         S_PAYLOAD: begin
            if (cnt_q == PAY_TC) begin
               ser_d   = 1'b1;
               cnt_d   = '0;
               state_d = (GAP_CYCLES != 0) ? S_GAP : S_IDLE;
            end else begin
               ser_d = sh_q[SH_W-1];
               sh_d  = {sh_q[SH_W-2:0], 1'b0};
            end
         end
         S_GAP: begin
            ser_d = 1'b1;
            if (cnt_q == GAP_TC) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            ser_d   = 1'b1;
         end
      endcase
   end

endmodule
